// File: rtl/hl_layer_pkg.sv
// hl_layer_pkg: shared state encoding and index-width helper for the layer collector
package hl_layer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2} state_e;
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/hl_capture_bank.sv
// hl_capture_bank: per-neuron result buffer with capture mask, all-captured detect and indexed read
//   clk_i/rst_i    clock, async active-high reset
//   clr_i          clear the capture mask (new vector)
//   cap_en_i       captures allowed this cycle
//   valid_i        per-neuron result-valid pulses
//   value_i        packed neuron results, neuron k at [k*WIDTH +: WIDTH]
//   rd_idx_i       read index; rd_data_o is the buffered value at that index
//   new_o          neurons captured this cycle
//   dup_o          a valid arrived for an already-captured neuron
//   done_o         every neuron is captured once this cycle's captures land
module hl_capture_bank
  import hl_layer_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_width(NUM_NEURONS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         cap_en_i,
  input  logic [NUM_NEURONS-1:0]       valid_i,
  input  logic [NUM_NEURONS*WIDTH-1:0] value_i,
  input  logic [IDX_W-1:0]             rd_idx_i,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic [NUM_NEURONS-1:0]       new_o,
  output logic                         dup_o,
  output logic                         done_o
);
  logic [NUM_NEURONS-1:0] mask_q;
  logic [WIDTH-1:0]       mem_q [NUM_NEURONS];
  assign new_o     = cap_en_i ? valid_i & ~mask_q : '0;
  assign dup_o     = |(valid_i & mask_q);
  assign done_o    = &(mask_q | new_o);
  assign rd_data_o = mem_q[rd_idx_i];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q <= '0;
      for (int k = 0; k < NUM_NEURONS; k++) mem_q[k] <= '0;
    end else begin
      mask_q <= clr_i ? '0 : mask_q | new_o;
      for (int k = 0; k < NUM_NEURONS; k++)
        if (new_o[k]) mem_q[k] <= value_i[k*WIDTH +: WIDTH];
    end
  end
endmodule

// File: rtl/hl_layer_collector.sv
// hl_layer_collector: gathers out-of-order neuron results and streams the layer vector in index order
//   CLK/RST              clock, async active-high reset
//   START                new input vector issued to the layer
//   NEURON_*_IN          per-neuron value, valid pulse, sticky overflow and ready flags
//   LAYER_READY          idle and all neurons ready
//   VALUE_OUT/INDEX_OUT  streamed element and its neuron index, with VALID_OUT/LAST_OUT, READY_IN
//   OVERFLOW_OUT         OR of overflows captured for the current vector
//   PROTOCOL_ERR         sticky illegal-event flag
module hl_layer_collector
  import hl_layer_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int WIDTH = 8,
  localparam int IDX_W = idx_width(NUM_NEURONS)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic [NUM_NEURONS*WIDTH-1:0] NEURON_VALUE_IN,
  input  logic [NUM_NEURONS-1:0]       NEURON_VALID_IN,
  input  logic [NUM_NEURONS-1:0]       NEURON_OVERFLOW_IN,
  input  logic [NUM_NEURONS-1:0]       NEURON_READY_IN,
  output logic                         LAYER_READY,
  output logic [WIDTH-1:0]             VALUE_OUT,
  output logic [IDX_W-1:0]             INDEX_OUT,
  output logic                         VALID_OUT,
  output logic                         LAST_OUT,
  input  logic                         READY_IN,
  output logic                         OVERFLOW_OUT,
  output logic                         PROTOCOL_ERR
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q, rd_idx_d;
  logic [WIDTH-1:0]       value_q, rd_data;
  logic                   valid_q, last_q, ovf_q, err_q, err_d;
  logic [NUM_NEURONS-1:0] new_w;
  logic                   dup_w, done_w, any_v;
  hl_capture_bank #(.NUM_NEURONS(NUM_NEURONS), .WIDTH(WIDTH), .IDX_W(IDX_W)) u_bank (
    .clk_i    (CLK),
    .rst_i    (RST),
    .clr_i    (state_q == IDLE && START),
    .cap_en_i (state_q == COLLECT),
    .valid_i  (NEURON_VALID_IN),
    .value_i  (NEURON_VALUE_IN),
    .rd_idx_i (rd_idx_d),
    .rd_data_o(rd_data),
    .new_o    (new_w),
    .dup_o    (dup_w),
    .done_o   (done_w)
  );
  assign any_v    = |NEURON_VALID_IN;
  // Read one element ahead while presenting so back-to-back handshakes need no bubble.
  assign rd_idx_d = valid_q ? idx_q + IDX_W'(1) : idx_q;
  assign err_d    = err_q | (state_q == IDLE ? any_v : state_q == COLLECT ? START | dup_w : START | any_v);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        IDLE: if (START) begin
          state_q <= COLLECT;
          ovf_q   <= 1'b0;
        end
        COLLECT: begin
          ovf_q <= ovf_q | |(new_w & NEURON_OVERFLOW_IN);
          if (done_w) begin
            state_q <= DRAIN;
            idx_q   <= '0;
          end
        end
        DRAIN: if (!valid_q) begin
          valid_q <= 1'b1;
          value_q <= rd_data;
          last_q  <= idx_q == LAST_IDX;
        end else if (READY_IN) begin
          if (last_q) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
          end else begin
            idx_q   <= rd_idx_d;
            value_q <= rd_data;
            last_q  <= rd_idx_d == LAST_IDX;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign LAYER_READY  = state_q == IDLE && &NEURON_READY_IN;
  assign VALUE_OUT    = value_q;
  assign INDEX_OUT    = idx_q;
  assign VALID_OUT    = valid_q;
  assign LAST_OUT     = last_q;
  assign OVERFLOW_OUT = ovf_q;
  assign PROTOCOL_ERR = err_q;
endmodule

// File: tb/tb_hl_layer_collector.sv
// tb_hl_layer_collector: directed self-checking bench for hl_layer_collector (4 neurons x 8 bits)
module tb_hl_layer_collector;
  logic        CLK = 0, RST = 1, START = 0, READY_IN = 1;
  logic [31:0] NEURON_VALUE_IN = '0;
  logic [3:0]  NEURON_VALID_IN = '0, NEURON_OVERFLOW_IN = '0, NEURON_READY_IN = 4'b1111;
  logic        LAYER_READY, VALID_OUT, LAST_OUT, OVERFLOW_OUT, PROTOCOL_ERR;
  logic [7:0]  VALUE_OUT;
  logic [1:0]  INDEX_OUT;
  int          n_chk = 0, n_fail = 0;
  hl_layer_collector #(.NUM_NEURONS(4), .WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .NEURON_VALUE_IN(NEURON_VALUE_IN), .NEURON_VALID_IN(NEURON_VALID_IN),
    .NEURON_OVERFLOW_IN(NEURON_OVERFLOW_IN), .NEURON_READY_IN(NEURON_READY_IN),
    .LAYER_READY(LAYER_READY), .VALUE_OUT(VALUE_OUT), .INDEX_OUT(INDEX_OUT),
    .VALID_OUT(VALID_OUT), .LAST_OUT(LAST_OUT), .READY_IN(READY_IN),
    .OVERFLOW_OUT(OVERFLOW_OUT), .PROTOCOL_ERR(PROTOCOL_ERR)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic pulse_start();
    START = 1;
    step();
    START = 0;
  endtask
  task automatic vec(input logic [3:0] v, input logic [31:0] val, input logic [3:0] o);
    NEURON_VALID_IN = v;
    NEURON_VALUE_IN = val;
    NEURON_OVERFLOW_IN = o;
    step();
    NEURON_VALID_IN = '0;
    NEURON_OVERFLOW_IN = '0;
  endtask
  task automatic drain(input logic [31:0] exp, input logic ovf);
    int n = 0;
    READY_IN = 1;
    while (!VALID_OUT && n < 10) begin
      step();
      n++;
    end
    chk("valid_seen", VALID_OUT, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("value[%0d]", i), VALUE_OUT, exp[i*8 +: 8]);
      chk($sformatf("index[%0d]", i), INDEX_OUT, i);
      chk($sformatf("last[%0d]", i), LAST_OUT, i == 3);
      chk("layer_ready_drain", LAYER_READY, 0);
      chk("ovf_drain", OVERFLOW_OUT, ovf);
      step();
    end
    chk("valid_after_last", VALID_OUT, 0);
    chk("layer_ready_idle", LAYER_READY, 1);
  endtask
  initial begin
    logic [6:0]  rdy_pat = 7'b1011001;
    logic [31:0] v2 = 32'hFF01807F;
    int          hs = 0, ei = 0;
    step();
    step();
    chk("rst_valid", VALID_OUT, 0);
    chk("rst_value", VALUE_OUT, 0);
    chk("rst_index", INDEX_OUT, 0);
    chk("rst_last", LAST_OUT, 0);
    chk("rst_ovf", OVERFLOW_OUT, 0);
    chk("rst_err", PROTOCOL_ERR, 0);
    RST = 0;
    step();
    NEURON_READY_IN = 4'b1011;
    #1 chk("layer_ready_partial", LAYER_READY, 0);
    NEURON_READY_IN = 4'b1111;
    #1 chk("layer_ready_all", LAYER_READY, 1);
    // out-of-order arrival
    pulse_start();
    chk("layer_ready_collect", LAYER_READY, 0);
    vec(4'b1000, 32'h11000000, 0);
    vec(4'b0001, 32'h00000022, 0);
    vec(4'b0100, 32'h00330000, 0);
    vec(4'b0010, 32'h00004400, 0);
    chk("latency_not_yet", VALID_OUT, 0);
    step();
    chk("latency_valid", VALID_OUT, 1);
    drain(32'h11334422, 0);
    // all at once with stalls
    pulse_start();
    vec(4'b1111, v2, 0);
    step();
    for (int p = 6; p >= 0; p--) begin
      READY_IN = rdy_pat[p];
      chk("stall_valid", VALID_OUT, 1);
      chk("stall_index", INDEX_OUT, ei);
      chk("stall_value", VALUE_OUT, v2[ei*8 +: 8]);
      chk("stall_last", LAST_OUT, ei == 3);
      if (rdy_pat[p]) begin
        hs++;
        ei++;
      end
      step();
    end
    READY_IN = 1;
    chk("handshakes", hs, 4);
    chk("stall_idle", VALID_OUT, 0);
    chk("stall_layer_ready", LAYER_READY, 1);
    // overflow aggregation
    pulse_start();
    vec(4'b0011, 32'h00002010, 0);
    vec(4'b0100, 32'h00300000, 4'b0100);
    chk("ovf_set", OVERFLOW_OUT, 1);
    vec(4'b1000, 32'h40000000, 0);
    drain(32'h40302010, 1);
    chk("ovf_hold_idle", OVERFLOW_OUT, 1);
    chk("err_clean", PROTOCOL_ERR, 0);
    pulse_start();
    chk("ovf_cleared", OVERFLOW_OUT, 0);
    // duplicate valid, START during drain
    READY_IN = 0;
    vec(4'b0010, 32'h00000500, 0);
    vec(4'b0010, 32'h00000900, 0);
    chk("err_dup", PROTOCOL_ERR, 1);
    vec(4'b1101, 32'hD3C209A0, 0);
    pulse_start();
    drain(32'hD3C205A0, 0);
    // reset mid-drain
    pulse_start();
    vec(4'b1111, 32'h0D0C0B0A, 0);
    step();
    step();
    step();
    chk("mid_drain_index", INDEX_OUT, 2);
    RST = 1;
    #1;
    chk("rst_async_valid", VALID_OUT, 0);
    chk("rst_async_idle", LAYER_READY, 1);
    chk("rst_async_err", PROTOCOL_ERR, 0);
    step();
    RST = 0;
    step();
    step();
    chk("post_rst_no_stream", VALID_OUT, 0);
    pulse_start();
    vec(4'b1111, 32'h44332211, 0);
    drain(32'h44332211, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
